// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry elastic instruction queue between fetch and decode.
// Presents a NOP bubble when empty; flush drops every entry in one cycle.
module if_id_queue #(
  parameter int unsigned      PC_W    = 32,
  parameter int unsigned      INS_W   = 32,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h0000_0000)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [PC_W-1:0]              pcPlusOne_i,
  input  logic [INS_W-1:0]             instruction_i,
  input  logic                         flush_i,
  input  logic                         pop_ready_i,
  output logic                         pop_valid_o,
  output logic [PC_W-1:0]              pcPlusOne_o,
  output logic [INS_W-1:0]             instruction_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wp_q, wp_d;
  logic [PTR_W-1:0]   rp_q, rp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               do_push;
  logic               do_pop;
  entry_t             head;

  // Handshake qualification and next-state for pointers and occupancy.
  always_comb begin
    push_ready_o = (cnt_q != CNT_W'(DEPTH));
    pop_valid_o  = (cnt_q != CNT_W'(0));
    do_push      = push_valid_i && push_ready_o && !flush_i;
    do_pop       = pop_ready_i && pop_valid_o && !flush_i;
    wp_d         = wp_q;
    rp_d         = rp_q;
    cnt_d        = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wp_d = wp_q + PTR_W'(1);
      if (do_pop)  rp_d = rp_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are left untouched by flush and reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wp_q] <= '{pc: pcPlusOne_i, ins: instruction_i};
    end
  end

  // Head view, gated to the bubble values when empty.
  always_comb begin
    head          = mem_q[rp_q];
    pcPlusOne_o   = pop_valid_o ? head.pc  : '0;
    instruction_o = pop_valid_o ? head.ins : NOP_INS;
    count_o       = cnt_q;
  end

endmodule
